// File: rtl/mode_requester_if.sv
// mode_requester_if: mode-request bus between the button requester (master)
// and the display mode FSM (slave), which echoes the accepted code on active.
interface mode_requester_if;
    logic [1:0] mode_req;
    logic [1:0] active;
    logic       busy;
    logic       err;

    modport master (output mode_req, output busy, output err, input active);
    modport slave  (input mode_req, input busy, input err, output active);
endinterface

// File: rtl/mode_requester.sv
// mode_requester: three push buttons -> held 2-bit mode request with ack timeout.
// Define DEBOUNCE_EN to include the per-button debouncer; otherwise the synced level is used directly.
module mode_btn #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("mode_btn: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [1:0] r_sync;
    logic       r_lvl_d;
    logic       w_lvl;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[0], i_btn};

`ifdef DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [CW-1:0] r_cnt;
    logic          r_lvl;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
        end else if (r_sync[1] == r_lvl) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt <= '0;
            r_lvl <= ~r_lvl;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    assign w_lvl = r_lvl;
`else
    assign w_lvl = r_sync[1];
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) r_lvl_d <= 1'b0;
        else       r_lvl_d <= w_lvl;

    assign o_press = w_lvl & ~r_lvl_d;
endmodule

module mode_requester #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACK_TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_btn_grid,
    input  logic             i_btn_lfsr,
    input  logic             i_btn_evolve,
    mode_requester_if.master bus
);
    if (ACK_TIMEOUT < 2) begin : g_bad_to
        $error("mode_requester: ACK_TIMEOUT must be >= 2");
    end

    localparam int          TW        = $clog2(ACK_TIMEOUT);
    localparam logic [1:0]  C_GRID    = 2'b00;
    localparam logic [1:0]  C_EVOLVE  = 2'b01;
    localparam logic [1:0]  C_LFSR    = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    logic [2:0] w_btn, w_press;
    logic       w_vld;
    logic [1:0] w_code;
    logic [1:0] w_pend_code;
    logic       w_pend_vld;

    assign w_btn = {i_btn_evolve, i_btn_lfsr, i_btn_grid};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        mode_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk    (clk),
            .reset  (reset),
            .i_btn  (w_btn[g]),
            .o_press(w_press[g])
        );
    end

    // Simultaneous presses resolve grid > evolve > lfsr; losers are dropped.
    always_comb begin
        w_code = C_LFSR;
        if (w_press[0])      w_code = C_GRID;
        else if (w_press[2]) w_code = C_EVOLVE;
    end
    assign w_vld = |w_press;

    state_t        r_state;
    logic [1:0]    r_mode, r_pend;
    logic          r_pend_vld, r_busy, r_err;
    logic [TW-1:0] r_timer;

    // A press in the same cycle as the ack is newer than anything already pending.
    assign w_pend_code = w_vld ? w_code : r_pend;
    assign w_pend_vld  = w_vld | r_pend_vld;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state    <= IDLE;
            r_mode     <= C_GRID;
            r_pend     <= 2'b00;
            r_pend_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_vld) begin
                    r_mode  <= w_code;
                    r_timer <= '0;
                    r_busy  <= 1'b1;
                    r_state <= REQ;
                end
                REQ: begin
                    r_pend <= w_pend_code;
                    if (bus.active == r_mode) begin
                        r_err      <= 1'b0;
                        r_busy     <= 1'b0;
                        r_pend_vld <= w_pend_vld && (w_pend_code != r_mode);
                        r_state    <= HOLD;
                    end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                        r_err      <= 1'b1;
                        r_busy     <= 1'b0;
                        r_mode     <= C_GRID;
                        r_pend_vld <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_pend_vld <= w_pend_vld;
                        r_timer    <= r_timer + TW'(1);
                    end
                end
                HOLD: begin
                    if (w_vld && (w_code != r_mode)) begin
                        r_mode     <= w_code;
                        r_timer    <= '0;
                        r_busy     <= 1'b1;
                        r_pend_vld <= 1'b0;
                        r_state    <= REQ;
                    end else if (r_pend_vld) begin
                        r_mode     <= r_pend;
                        r_timer    <= '0;
                        r_busy     <= 1'b1;
                        r_pend_vld <= 1'b0;
                        r_state    <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end

    assign bus.mode_req = r_mode;
    assign bus.busy     = r_busy;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_mode_requester.sv
// tb_mode_requester: table of button presses plus hand-written pending/reset sequences;
// expected outputs are queued with their due cycle and compared as the cycle arrives.
module tb_mode_requester;
    localparam int DB = 4;
    localparam int AT = 8;
`ifdef DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    localparam int LAT  = DB_EN ? (2 + DB + 1) : 3;
    localparam int WAIT = LAT + AT + 14;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn = 3'b000;   // {evolve, lfsr, grid}
    int         cyc = 0;
    int         ack_dly = 1;    // 0: FSM never acknowledges
    logic [3:0][1:0] dl;

    mode_requester_if bus();

    mode_requester #(.DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(AT)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn_grid  (btn[0]),
        .i_btn_lfsr  (btn[1]),
        .i_btn_evolve(btn[2]),
        .bus         (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mode FSM stand-in: echoes mode_req after ack_dly cycles; 2'b10 never matches.
    always @(posedge clk) dl <= {dl[2:0], bus.mode_req};
    assign bus.active = (ack_dly == 0) ? 2'b10 : dl[2'(ack_dly - 1)];

    typedef struct {
        int         cyc;
        int         tag;
        logic [1:0] mode;
        logic       busy;
        logic       err;
    } exp_t;

    typedef struct {
        logic [2:0] btn;
        int         high;
        int         dly;
        logic [1:0] req_mode;
        int         busy_cyc;   // 0: no request expected
        logic [1:0] fin_mode;
        logic       fin_err;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int c, input int tag, input logic [1:0] m,
                             input logic b, input logic e);
        exp_t x;
        x.cyc = c; x.tag = tag; x.mode = m; x.busy = b; x.err = e;
        sb.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            checks++;
            if (x.cyc != cyc || bus.mode_req !== x.mode || bus.busy !== x.busy || bus.err !== x.err) begin
                errors++;
                $display("FAIL chk%0d @cyc%0d (due %0d): mode=%b busy=%b err=%b, want mode=%b busy=%b err=%b",
                         x.tag, cyc, x.cyc, bus.mode_req, bus.busy, bus.err, x.mode, x.busy, x.err);
            end
        end
    end

    vec_t vt[9];

    initial begin
        int t0;
        logic [1:0] pm;
        logic       pe;

        vt[0] = '{3'b010, 10, 1, 2'b11, 2,  2'b11, 1'b0};
        if (DB_EN) begin
            vt[1] = '{3'b100, 2, 1, 2'b11, 0, 2'b11, 1'b0};
            vt[2] = '{3'b100, 6, 1, 2'b01, 2, 2'b01, 1'b0};
        end else begin
            vt[1] = '{3'b100, 2, 1, 2'b01, 2, 2'b01, 1'b0};
            vt[2] = '{3'b100, 6, 1, 2'b01, 0, 2'b01, 1'b0};
        end
        vt[3] = '{3'b001, 5, 1, 2'b00, 2,  2'b00, 1'b0};
        vt[4] = '{3'b100, 4, 2, 2'b01, 3,  2'b01, 1'b0};
        vt[5] = '{3'b100, 4, 1, 2'b01, 0,  2'b01, 1'b0};
        vt[6] = '{3'b011, 6, 1, 2'b00, 2,  2'b00, 1'b0};
        vt[7] = '{3'b010, 6, 0, 2'b11, AT, 2'b00, 1'b1};
        vt[8] = '{3'b001, 6, 1, 2'b00, 1,  2'b00, 1'b0};

        // Reset state, then idle with buttons low.
        repeat (3) @(negedge clk);
        expect_at(cyc + 1, 0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        expect_at(t0 + 1,  1, 2'b00, 1'b0, 1'b0);
        expect_at(t0 + 10, 2, 2'b00, 1'b0, 1'b0);
        expect_at(t0 + 20, 3, 2'b00, 1'b0, 1'b0);
        repeat (22) @(negedge clk);

        pm = 2'b00;
        pe = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ack_dly = vt[i].dly;
            @(negedge clk);
            t0  = cyc;
            btn = vt[i].btn;
            if (vt[i].busy_cyc > 0) begin
                expect_at(t0 + LAT - 1, 100*i + 1, pm, 1'b0, pe);
                expect_at(t0 + LAT, 100*i + 2, vt[i].req_mode, 1'b1, pe);
                expect_at(t0 + LAT + vt[i].busy_cyc - 1, 100*i + 3, vt[i].req_mode, 1'b1, pe);
                expect_at(t0 + LAT + vt[i].busy_cyc, 100*i + 4, vt[i].fin_mode, 1'b0, vt[i].fin_err);
                expect_at(t0 + LAT + vt[i].busy_cyc + 6, 100*i + 5, vt[i].fin_mode, 1'b0, vt[i].fin_err);
            end else begin
                expect_at(t0 + LAT,     100*i + 6, pm, 1'b0, pe);
                expect_at(t0 + LAT + 1, 100*i + 7, pm, 1'b0, pe);
                expect_at(t0 + LAT + 6, 100*i + 8, pm, 1'b0, pe);
            end
            for (int k = 1; k <= WAIT; k++) begin
                @(negedge clk);
                if (k == vt[i].high) btn = 3'b000;
            end
            pm = vt[i].fin_mode;
            pe = vt[i].fin_err;
        end

        // Evolve arrives while LFSR awaits a slow ack; then reset aborts the follow-on request.
        ack_dly = 3;
        @(negedge clk);
        t0  = cyc;
        btn = 3'b010;
        expect_at(t0 + LAT,     901, 2'b11, 1'b1, 1'b0);
        expect_at(t0 + LAT + 3, 902, 2'b11, 1'b1, 1'b0);
        expect_at(t0 + LAT + 4, 903, 2'b11, 1'b0, 1'b0);
        expect_at(t0 + LAT + 5, 904, 2'b01, 1'b1, 1'b0);
        expect_at(t0 + LAT + 6, 905, 2'b01, 1'b1, 1'b0);
        expect_at(t0 + LAT + 7, 906, 2'b00, 1'b0, 1'b0);
        expect_at(t0 + LAT + 9, 907, 2'b00, 1'b0, 1'b0);
        expect_at(t0 + LAT + 20, 908, 2'b00, 1'b0, 1'b0);
        for (int k = 1; k <= LAT + 22; k++) begin
            @(negedge clk);
            if (k == 1)       btn = 3'b110;
            if (k == 6)       btn = 3'b000;
            if (k == LAT + 6) reset = 1'b1;
            if (k == LAT + 8) reset = 1'b0;
        end

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL leftover: %0d expectations never reached, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
